// File: rtl/fir_tap_loader_pkg.sv
// ---------------------------------------------------------------------------
// fir_tap_pkg
// Shared types and helpers for the FIR tap loader.
//   loader_state_e : loader FSM states
//   TAP_IDX_W()    : width of a tap index for a given tap count
// ---------------------------------------------------------------------------
package fir_tap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    STREAM,
    WAIT_DONE,
    DONE
  } loader_state_e;

  // Width needed to index num_taps entries (num_taps is always >= 2 here).
  function automatic int TAP_IDX_W(input int num_taps);
    return (num_taps > 1) ? $clog2(num_taps) : 1;
  endfunction

endpackage

// File: rtl/fir_tap_loader_if.sv
// ---------------------------------------------------------------------------
// fir_tap_loader_if
// Bundles the host configuration port, the control/status flags and the
// valid/ready tap link to the FIR.
//   master : loader view (drives status, tap_dout, tap_dout_valid, fir_enable)
//   slave  : host + FIR view (drives writes, start, ready, done)
// ---------------------------------------------------------------------------
interface fir_tap_loader_if #(
  parameter int G_NUM_TAPS  = 16,
  parameter int G_TAP_WIDTH = 16
);
  localparam int ADDR_W = $clog2(G_NUM_TAPS) + 1;

  logic [ADDR_W-1:0]      cfg_wr_addr;
  logic [G_TAP_WIDTH-1:0] cfg_wr_data;
  logic                   cfg_wr_valid;
  logic                   cfg_wr_err;
  logic                   start;
  logic                   busy;
  logic                   load_ok;
  logic                   load_err;
  logic                   fir_enable;
  logic [G_TAP_WIDTH-1:0] tap_dout;
  logic                   tap_dout_valid;
  logic                   tap_dout_ready;
  logic                   tap_done_in;

  modport master (
    input  cfg_wr_addr, cfg_wr_data, cfg_wr_valid, start,
    input  tap_dout_ready, tap_done_in,
    output cfg_wr_err, busy, load_ok, load_err,
    output fir_enable, tap_dout, tap_dout_valid
  );

  modport slave (
    output cfg_wr_addr, cfg_wr_data, cfg_wr_valid, start,
    output tap_dout_ready, tap_done_in,
    input  cfg_wr_err, busy, load_ok, load_err,
    input  fir_enable, tap_dout, tap_dout_valid
  );
endinterface

// File: rtl/fir_tap_loader_store.sv
// ---------------------------------------------------------------------------
// fir_tap_store
// Coefficient store: one write port, one synchronous read port with a single
// cycle of read latency. Contents survive reset.
//   clk       : clock
//   wr_en_i   : write strobe
//   wr_addr_i : write index
//   wr_data_i : write coefficient
//   rd_addr_i : read index (registered into rd_data_o on each edge)
//   rd_data_o : coefficient read on the previous edge
// ---------------------------------------------------------------------------
module fir_tap_store
  import fir_tap_pkg::*;
#(
  parameter int G_NUM_TAPS  = 16,
  parameter int G_TAP_WIDTH = 16,
  localparam int IDX_W      = TAP_IDX_W(G_NUM_TAPS)
) (
  input  logic                   clk,
  input  logic                   wr_en_i,
  input  logic [IDX_W-1:0]       wr_addr_i,
  input  logic [G_TAP_WIDTH-1:0] wr_data_i,
  input  logic [IDX_W-1:0]       rd_addr_i,
  output logic [G_TAP_WIDTH-1:0] rd_data_o
);

  logic [G_TAP_WIDTH-1:0] mem_q [G_NUM_TAPS];
  logic [G_TAP_WIDTH-1:0] rd_data_q;

  // Plain RAM behaviour with no reset so the host's coefficients are kept
  // across a loader reset; the read port is sampled every cycle.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fir_tap_loader.sv
// ---------------------------------------------------------------------------
// fir_tap_loader
// Programs the FIR's coefficients: holds the FIR in restart (enable low) for
// a few cycles, streams every stored tap in index order over valid/ready,
// then waits for the FIR's tap-done flag with a timeout.
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : host writes/start/status and FIR tap link (master modport)
// ---------------------------------------------------------------------------
module fir_tap_loader
  import fir_tap_pkg::*;
#(
  parameter int G_NUM_TAPS     = 16,
  parameter int G_TAP_WIDTH    = 16,
  parameter int G_FLUSH_CYCLES = 2,
  parameter int G_DONE_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  fir_tap_loader_if.master  bus
);

  localparam int IDX_W   = TAP_IDX_W(G_NUM_TAPS);
  localparam int ADDR_W  = $clog2(G_NUM_TAPS) + 1;
  localparam int FLUSH_W = $clog2(G_FLUSH_CYCLES + 1);
  localparam int TMO_W   = $clog2(G_DONE_TIMEOUT + 1);

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(G_NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LIMIT = ADDR_W'(G_NUM_TAPS);
  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(G_FLUSH_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(G_DONE_TIMEOUT - 1);

  loader_state_e        state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                 busy_q, busy_d;
  logic                 load_ok_q, load_ok_d;
  logic                 load_err_q, load_err_d;
  logic                 fir_en_q, fir_en_d;
  logic                 valid_q, valid_d;
  logic                 wr_err_q, wr_err_d;

  logic                   wr_accept;
  logic                   handshake;
  logic [IDX_W-1:0]       rd_addr;
  logic [G_TAP_WIDTH-1:0] rd_data;

  // Host writes only land while idle and in range; anything else is flagged
  // on the following cycle. The read address runs one step ahead on a
  // handshake so the next tap is already registered when idx advances.
  always_comb begin
    wr_accept = bus.cfg_wr_valid && (state_q == IDLE) && (bus.cfg_wr_addr < ADDR_LIMIT);
    wr_err_d  = bus.cfg_wr_valid && !wr_accept;
    handshake = valid_q && bus.tap_dout_ready;
    rd_addr   = idx_q;
    if (handshake && (idx_q != LAST_IDX)) begin
      rd_addr = idx_q + 1'b1;
    end
  end

  fir_tap_store #(
    .G_NUM_TAPS  (G_NUM_TAPS),
    .G_TAP_WIDTH (G_TAP_WIDTH)
  ) u_store (
    .clk       (clk),
    .wr_en_i   (wr_accept),
    .wr_addr_i (bus.cfg_wr_addr[IDX_W-1:0]),
    .wr_data_i (bus.cfg_wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Next-state logic. The index is compared against the last tap rather than
  // relying on wrap-around, so any tap count works.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    flush_cnt_d = flush_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    busy_d      = busy_q;
    load_ok_d   = load_ok_q;
    load_err_d  = load_err_q;
    fir_en_d    = fir_en_q;
    valid_d     = valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = FLUSH;
          busy_d      = 1'b1;
          load_ok_d   = 1'b0;
          load_err_d  = 1'b0;
          fir_en_d    = 1'b0;
          flush_cnt_d = FLUSH_INIT;
          idx_d       = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d  = STREAM;
          fir_en_d = 1'b1;
          valid_d  = 1'b1;
          idx_d    = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      STREAM: begin
        if (handshake) begin
          if (idx_q == LAST_IDX) begin
            state_d   = WAIT_DONE;
            valid_d   = 1'b0;
            tmo_cnt_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        // A done flag seen on the final timeout cycle still counts as success.
        if (bus.tap_done_in) begin
          state_d   = DONE;
          load_ok_d = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d    = DONE;
          load_err_d = 1'b1;
          fir_en_d   = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops the link and the FIR enable immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      flush_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      busy_q      <= 1'b0;
      load_ok_q   <= 1'b0;
      load_err_q  <= 1'b0;
      fir_en_q    <= 1'b0;
      valid_q     <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      flush_cnt_q <= flush_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      busy_q      <= busy_d;
      load_ok_q   <= load_ok_d;
      load_err_q  <= load_err_d;
      fir_en_q    <= fir_en_d;
      valid_q     <= valid_d;
      wr_err_q    <= wr_err_d;
    end
  end

  // The store has no reset, so the data path is gated by valid to present
  // zero whenever no tap is offered.
  assign bus.tap_dout       = valid_q ? rd_data : '0;
  assign bus.tap_dout_valid = valid_q;
  assign bus.fir_enable     = fir_en_q;
  assign bus.busy           = busy_q;
  assign bus.load_ok        = load_ok_q;
  assign bus.load_err       = load_err_q;
  assign bus.cfg_wr_err     = wr_err_q;

endmodule

// File: tb/tb_fir_tap_loader.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_loader
// Self-checking bench for fir_tap_loader. Expected taps are queued when a
// load is started and popped by a monitor on every observed handshake.
// ---------------------------------------------------------------------------
module tb_fir_tap_loader;

  localparam int N = 16;
  localparam int W = 16;
  localparam int F = 2;
  localparam int T = 64;

  logic clk = 1'b0;
  logic reset;

  fir_tap_loader_if #(.G_NUM_TAPS(N), .G_TAP_WIDTH(W)) bus ();

  fir_tap_loader #(
    .G_NUM_TAPS     (N),
    .G_TAP_WIDTH    (W),
    .G_FLUSH_CYCLES (F),
    .G_DONE_TIMEOUT (T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int totalChecks = 0;
  int badChecks   = 0;
  int cyc         = 0;
  int xferCount   = 0;
  int firstHsCyc  = 0;
  int lastHsCyc   = 0;
  logic [W-1:0] firstHsData;
  logic [W-1:0] modelTaps [N];
  logic [W-1:0] expQ [$];
  bit           stallPrev = 1'b0;
  logic [W-1:0] stallData;

  // Free-running edge counter for latency/throughput checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: sampled on the falling edge, a valid&&ready here is
  // the transfer that completes at the next rising edge.
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        totalChecks++;
        if (bus.tap_dout_valid !== 1'b1 || bus.tap_dout !== stallData) begin
          badChecks++;
          $display("[TB] FAIL stall_hold: got valid=%b data=%h, expected valid=1 data=%h",
                   bus.tap_dout_valid, bus.tap_dout, stallData);
        end
      end
      if (bus.tap_dout_valid === 1'b1 && bus.tap_dout_ready === 1'b1) begin
        totalChecks++;
        if (expQ.size() == 0) begin
          badChecks++;
          $display("[TB] FAIL unexpected_xfer: got data=%h, expected no transfer", bus.tap_dout);
        end else begin
          logic [W-1:0] expv;
          expv = expQ.pop_front();
          if (bus.tap_dout !== expv) begin
            badChecks++;
            $display("[TB] FAIL tap_data: got %h, expected %h (xfer %0d)", bus.tap_dout, expv, xferCount);
          end
        end
        if (xferCount == 0) begin
          firstHsCyc  = cyc;
          firstHsData = bus.tap_dout;
        end
        lastHsCyc = cyc;
        xferCount++;
      end
      stallPrev = (bus.tap_dout_valid === 1'b1) && (bus.tap_dout_ready === 1'b0);
      stallData = bus.tap_dout;
    end
  end

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic write_all();
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      bus.cfg_wr_addr  = 5'(i);
      bus.cfg_wr_data  = 16'(i * 16'h0101);
      bus.cfg_wr_valid = 1'b1;
      modelTaps[i]     = 16'(i * 16'h0101);
    end
    @(posedge clk); #1;
    bus.cfg_wr_valid = 1'b0;
  endtask

  task automatic push_model();
    for (int i = 0; i < N; i++) expQ.push_back(modelTaps[i]);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Runs until the monitor has seen target transfers; mode 1 drives ready
  // in a 1,0,0 repeating pattern.
  task automatic wait_xfers(input int target, input int mode, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (xferCount >= target) begin
        ok = 1'b1;
        break;
      end
      bus.tap_dout_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
    end
  endtask

  task automatic test_reset();
    #12;
    totalChecks++;
    if ({bus.cfg_wr_err, bus.busy, bus.load_ok, bus.load_err, bus.fir_enable, bus.tap_dout_valid} !== 6'b0
        || bus.tap_dout !== '0) begin
      badChecks++;
      $display("[TB] FAIL reset_values: got err=%b busy=%b ok=%b lerr=%b en=%b valid=%b dout=%h, expected all 0",
               bus.cfg_wr_err, bus.busy, bus.load_ok, bus.load_err, bus.fir_enable, bus.tap_dout_valid, bus.tap_dout);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    totalChecks++;
    if (bus.busy !== 1'b0 || bus.tap_dout_valid !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL idle_after_reset: got busy=%b valid=%b, expected 0 0", bus.busy, bus.tap_dout_valid);
    end
  endtask

  task automatic test_full_load();
    bit ok;
    write_all();
    xferCount = 0;
    push_model();
    bus.tap_dout_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    totalChecks++;
    if (bus.busy !== 1'b1 || bus.fir_enable !== 1'b0 || bus.tap_dout_valid !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL flush_entry: got busy=%b en=%b valid=%b, expected 1 0 0",
               bus.busy, bus.fir_enable, bus.tap_dout_valid);
    end
    @(negedge clk);
    totalChecks++;
    if (bus.tap_dout_valid !== 1'b0 || bus.fir_enable !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL flush_hold: got valid=%b en=%b, expected 0 0", bus.tap_dout_valid, bus.fir_enable);
    end
    @(negedge clk);
    totalChecks++;
    if (bus.tap_dout_valid !== 1'b1 || bus.fir_enable !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL first_valid_latency: got valid=%b en=%b, expected 1 1", bus.tap_dout_valid, bus.fir_enable);
    end
    wait_xfers(N, 0, ok);
    totalChecks++;
    if (!ok) begin
      badChecks++;
      $display("[TB] FAIL full_xfers: got %0d transfers, expected %0d", xferCount, N);
    end
    totalChecks++;
    if (lastHsCyc - firstHsCyc !== N - 1) begin
      badChecks++;
      $display("[TB] FAIL throughput: got span %0d, expected %0d", lastHsCyc - firstHsCyc, N - 1);
    end
    bus.tap_done_in = 1'b1;
    @(posedge clk); #1;
    bus.tap_done_in = 1'b0;
    @(negedge clk);
    totalChecks++;
    if (bus.load_ok !== 1'b1 || bus.tap_dout_valid !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL done_ok: got ok=%b valid=%b, expected 1 0", bus.load_ok, bus.tap_dout_valid);
    end
    @(negedge clk);
    totalChecks++;
    if (bus.busy !== 1'b0 || bus.fir_enable !== 1'b1 || bus.load_ok !== 1'b1 || bus.load_err !== 1'b0
        || expQ.size() != 0 || xferCount != N) begin
      badChecks++;
      $display("[TB] FAIL full_end: got busy=%b en=%b ok=%b lerr=%b left=%0d xfers=%0d, expected 0 1 1 0 0 %0d",
               bus.busy, bus.fir_enable, bus.load_ok, bus.load_err, expQ.size(), xferCount, N);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    xferCount = 0;
    push_model();
    bus.tap_dout_ready = 1'b0;
    pulse_start();
    wait_xfers(N, 1, ok);
    totalChecks++;
    if (!ok) begin
      badChecks++;
      $display("[TB] FAIL bp_xfers: got %0d transfers, expected %0d", xferCount, N);
    end
    bus.tap_dout_ready = 1'b0;
    bus.tap_done_in    = 1'b1;
    @(posedge clk); #1;
    bus.tap_done_in = 1'b0;
    repeat (2) @(negedge clk);
    totalChecks++;
    if (xferCount != N || expQ.size() != 0 || bus.load_ok !== 1'b1 || bus.busy !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL bp_end: got xfers=%0d left=%0d ok=%b busy=%b, expected %0d 0 1 0",
               xferCount, expQ.size(), bus.load_ok, bus.busy, N);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    xferCount = 0;
    push_model();
    bus.tap_dout_ready = 1'b1;
    pulse_start();
    wait_xfers(N, 0, ok);
    totalChecks++;
    if (!ok) begin
      badChecks++;
      $display("[TB] FAIL tmo_xfers: got %0d transfers, expected %0d", xferCount, N);
    end
    repeat (T - 1) @(posedge clk);
    @(negedge clk);
    totalChecks++;
    if (bus.load_err !== 1'b0 || bus.busy !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL tmo_early: got lerr=%b busy=%b, expected 0 1", bus.load_err, bus.busy);
    end
    @(posedge clk);
    @(negedge clk);
    totalChecks++;
    if (bus.load_err !== 1'b1 || bus.fir_enable !== 1'b0 || bus.load_ok !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL tmo_fire: got lerr=%b en=%b ok=%b, expected 1 0 0",
               bus.load_err, bus.fir_enable, bus.load_ok);
    end
    @(negedge clk);
    totalChecks++;
    if (bus.busy !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL tmo_idle: got busy=%b, expected 0", bus.busy);
    end
  endtask

  task automatic test_bad_writes();
    bit ok;
    @(posedge clk); #1;
    bus.cfg_wr_addr  = 5'd16;
    bus.cfg_wr_data  = 16'hBEEF;
    bus.cfg_wr_valid = 1'b1;
    @(posedge clk); #1;
    bus.cfg_wr_valid = 1'b0;
    @(negedge clk);
    totalChecks++;
    if (bus.cfg_wr_err !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL err_range: got %b, expected 1", bus.cfg_wr_err);
    end
    @(negedge clk);
    totalChecks++;
    if (bus.cfg_wr_err !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL err_range_pulse: got %b, expected 0", bus.cfg_wr_err);
    end
    xferCount = 0;
    push_model();
    bus.tap_dout_ready = 1'b1;
    pulse_start();
    @(posedge clk); #1;
    bus.cfg_wr_addr  = 5'd3;
    bus.cfg_wr_data  = 16'hDEAD;
    bus.cfg_wr_valid = 1'b1;
    @(posedge clk); #1;
    bus.cfg_wr_valid = 1'b0;
    @(negedge clk);
    totalChecks++;
    if (bus.cfg_wr_err !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL err_busy: got %b, expected 1", bus.cfg_wr_err);
    end
    @(negedge clk);
    totalChecks++;
    if (bus.cfg_wr_err !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL err_busy_pulse: got %b, expected 0", bus.cfg_wr_err);
    end
    wait_xfers(N, 0, ok);
    bus.tap_done_in = 1'b1;
    @(posedge clk); #1;
    bus.tap_done_in = 1'b0;
    repeat (2) @(negedge clk);
    totalChecks++;
    if (!ok || xferCount != N || expQ.size() != 0 || bus.load_ok !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL bad_writes_load: got xfers=%0d left=%0d ok=%b, expected %0d 0 1",
               xferCount, expQ.size(), bus.load_ok, N);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    xferCount = 0;
    push_model();
    bus.tap_dout_ready = 1'b1;
    pulse_start();
    wait_xfers(5, 0, ok);
    pulse_start();
    wait_xfers(N, 0, ok);
    bus.tap_done_in = 1'b1;
    @(posedge clk); #1;
    bus.tap_done_in = 1'b0;
    repeat (6) @(negedge clk);
    totalChecks++;
    if (!ok || xferCount != N || expQ.size() != 0 || bus.tap_dout_valid !== 1'b0 || bus.busy !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL restart_ignored: got xfers=%0d left=%0d valid=%b busy=%b, expected %0d 0 0 0",
               xferCount, expQ.size(), bus.tap_dout_valid, bus.busy, N);
    end
    xferCount    = 0;
    modelTaps[0] = 16'h7FFF;
    push_model();
    @(posedge clk); #1;
    bus.cfg_wr_addr  = 5'd0;
    bus.cfg_wr_data  = 16'h7FFF;
    bus.cfg_wr_valid = 1'b1;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.cfg_wr_valid = 1'b0;
    bus.start        = 1'b0;
    @(negedge clk);
    totalChecks++;
    if (bus.cfg_wr_err !== 1'b0 || bus.busy !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL write_start_accept: got err=%b busy=%b, expected 0 1", bus.cfg_wr_err, bus.busy);
    end
    wait_xfers(N, 0, ok);
    totalChecks++;
    if (!ok || firstHsData !== 16'h7FFF) begin
      badChecks++;
      $display("[TB] FAIL write_start_first: got %h, expected 7fff", firstHsData);
    end
    bus.tap_done_in = 1'b1;
    @(posedge clk); #1;
    bus.tap_done_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    bit ok;
    xferCount = 0;
    push_model();
    bus.tap_dout_ready = 1'b1;
    pulse_start();
    wait_xfers(7, 0, ok);
    #2;
    reset = 1'b1;
    #1;
    totalChecks++;
    if (!ok || bus.tap_dout_valid !== 1'b0 || bus.fir_enable !== 1'b0 || bus.busy !== 1'b0
        || bus.tap_dout !== '0 || bus.load_ok !== 1'b0 || bus.load_err !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL async_reset: got valid=%b en=%b busy=%b dout=%h ok=%b lerr=%b, expected all 0",
               bus.tap_dout_valid, bus.fir_enable, bus.busy, bus.tap_dout, bus.load_ok, bus.load_err);
    end
    expQ.delete();
    @(negedge clk);
    reset = 1'b0;
    xferCount = 0;
    push_model();
    pulse_start();
    wait_xfers(N, 0, ok);
    bus.tap_done_in = 1'b1;
    @(posedge clk); #1;
    bus.tap_done_in = 1'b0;
    repeat (2) @(negedge clk);
    totalChecks++;
    if (!ok || xferCount != N || expQ.size() != 0 || firstHsData !== modelTaps[0] || bus.load_ok !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL reload_after_reset: got xfers=%0d left=%0d first=%h ok=%b, expected %0d 0 %h 1",
               xferCount, expQ.size(), firstHsData, bus.load_ok, N, modelTaps[0]);
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.cfg_wr_addr    = '0;
    bus.cfg_wr_data    = '0;
    bus.cfg_wr_valid   = 1'b0;
    bus.start          = 1'b0;
    bus.tap_dout_ready = 1'b0;
    bus.tap_done_in    = 1'b0;
    test_reset();
    test_full_load();
    test_backpressure();
    test_timeout();
    test_bad_writes();
    test_start_ignored();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
